id_ex_hazard_reg: RTL and testbench
===================================

Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, combined with load-use hazard detection.
- Captures decoded operands, register indices and control from ID. Drives ID_EXrs1/ID_EXrs2/ID_EXrd/ID_EXregWrite into the forwarding unit and EX-stage muxes.
- Inserts bubbles on load-use hazards and on branch flushes.
- Freezes under an external memory stall.

Parameters:
- XLEN, 32, datapath width
- CTRLW, 8, width of packed control vector {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[1:0]}
- CNTW, 16, width of saturating event counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- IF_IDrs1  in  5  rs1 of instruction in ID
- IF_IDrs2  in  5  rs2 of instruction in ID
- IF_IDrd  in  5  rd of instruction in ID
- IF_IDvalid  in  1  ID holds a real instruction
- ID_ctrl  in  CTRLW  decoded control vector
- ID_rdata1  in  XLEN  register file read port 1
- ID_rdata2  in  XLEN  register file read port 2
- ID_imm  in  XLEN  sign-extended immediate
- ID_pc  in  XLEN  PC of instruction in ID
- EX_flush  in  1  branch/jump taken in EX; kill ID/IF
- memStall  in  1  data memory not ready; freeze pipeline
- ID_EXrs1, ID_EXrs2, ID_EXrd  out  5 each  registered indices
- ID_EXctrl  out  CTRLW  registered control
- ID_EXregWrite, ID_EXmemRead  out  1  aliases of ID_EXctrl bits
- ID_EXrdata1, ID_EXrdata2, ID_EXimm, ID_EXpc  out  XLEN  registered data
- ID_EXvalid  out  1  EX holds a real instruction
- PCWrite  out  1  PC update enable
- IF_IDWrite  out  1  IF/ID register enable
- stallCount, flushCount  out  CNTW  saturating event counters

Behaviour:
- Reset (rst_n=0 at a clk edge): all registered outputs go to 0, including ID_EXvalid, both counters and the ctrl fields. Reset has priority over every other input, and a reset mid-stall or mid-flush discards the pending event.
- Hazard term, combinational from registered state and ID inputs:
  - loadUse = ID_EXvalid & ID_EXmemRead & (ID_EXrd != 0) & IF_IDvalid & ((ID_EXrd == IF_IDrs1) | (ID_EXrd == IF_IDrs2)).
  - x0 never causes a stall.
- Per-edge update, highest priority first:
  1. EX_flush=1: load bubble (ctrl=0, valid=0, indices=0, data don't-care but cleared to 0); flushCount+1. Flush beats memStall and loadUse.
  2. memStall=1: hold every ID/EX field unchanged; counters unchanged.
  3. loadUse=1: load bubble; stallCount+1.
  4. Otherwise: load all ID inputs; ID_EXvalid=IF_IDvalid. When IF_IDvalid=0, ctrl is forced to 0.
- PCWrite = IF_IDWrite = ~(memStall | (loadUse & ~EX_flush)).
  - These are combinational.
  - During reset assertion they follow the same equation from the reset-cleared registers, giving 1 one cycle after reset.
- Latency: exactly one cycle ID→EX. A load-use hazard costs exactly one bubble.
  - After the bubble, ID_EXmemRead=0, so loadUse deasserts and the held instruction proceeds.
  - The forwarding unit then supplies the load result via MEM/WB.
- Counters saturate at 2^CNTW−1 and do not wrap.
- Simultaneous loadUse and memStall: hold, no bubble, no stallCount increment. The hazard is re-evaluated when the stall releases.
- No sub-cycle combinational path from EX_flush into registered data beyond the priority mux.

Decomposition:
- Shared core package holds:
  - CTRLW and the bit-index constants for regWrite/memRead/memWrite/memToReg/aluSrc/branch/aluOp.
  - XLEN.
  - The x0 index constant.
- One natural sub-module: sat_counter (parameterised width, synchronous active-low clear, inc enable), instantiated twice for stallCount and flushCount.
- The hazard compare stays inline.

Test Plan:
- Reset: hold rst_n=0 two cycles with random inputs → all outputs 0, ID_EXvalid=0, counters 0. Release → PCWrite=1, IF_IDWrite=1.
- Load-use: EX holds lw x5 (memRead=1, rd=5); ID presents add x6,x5,x7 (rs1=5) → PCWrite=0 and IF_IDWrite=0 that cycle. Next edge: ID_EXctrl=0, ID_EXvalid=0, stallCount=1. Following edge: ID_EXrs1=5 loaded, valid=1.
- x0 / non-load: EX holds lw x0 with ID rs1=0 → no stall. EX holds add x5 (memRead=0) with ID rs2=5 → no stall, normal load.
- Flush priority: loadUse=1, memStall=1 and EX_flush=1 together → bubble loaded, flushCount=1, stallCount=0.
- memStall hold: load ID_pc=0x100 then assert memStall 3 cycles while ID_pc changes → ID_EXpc stays 0x100, PCWrite=0 for all 3 cycles. After release, next ID_pc is captured.
- Saturation: force 2^16+2 load-use events → stallCount=0xFFFF, no wrap. A reset mid-count returns it to 0.

Source files
------------

// File: rtl/id_ex_hazard_reg_pkg.sv
// rtl/id_ex_hazard_reg_pkg.sv - shared core constants for the ID/EX stage
package id_ex_hazard_reg_pkg;

  localparam int CORE_XLEN  = 32;
  localparam int CORE_CTRLW = 8;

  // Bit positions inside the packed control vector
  // {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[1:0]}
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  // Hard-wired zero register; writes to it never create a dependency
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use hazard detection
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int CTRLW = CORE_CTRLW,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_IDrs1,
  input  logic [4:0]       IF_IDrs2,
  input  logic [4:0]       IF_IDrd,
  input  logic             IF_IDvalid,
  input  logic [CTRLW-1:0] ID_ctrl,
  input  logic [XLEN-1:0]  ID_rdata1,
  input  logic [XLEN-1:0]  ID_rdata2,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic [XLEN-1:0]  ID_pc,
  input  logic             EX_flush,
  input  logic             memStall,
  output logic [4:0]       ID_EXrs1,
  output logic [4:0]       ID_EXrs2,
  output logic [4:0]       ID_EXrd,
  output logic [CTRLW-1:0] ID_EXctrl,
  output logic             ID_EXregWrite,
  output logic             ID_EXmemRead,
  output logic [XLEN-1:0]  ID_EXrdata1,
  output logic [XLEN-1:0]  ID_EXrdata2,
  output logic [XLEN-1:0]  ID_EXimm,
  output logic [XLEN-1:0]  ID_EXpc,
  output logic             ID_EXvalid,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic [CNTW-1:0]  stallCount,
  output logic [CNTW-1:0]  flushCount
);

  logic load_use;
  logic stall_event;

  assign ID_EXregWrite = ID_EXctrl[CTRL_REGWRITE];
  assign ID_EXmemRead  = ID_EXctrl[CTRL_MEMREAD];

  // A load in EX whose destination feeds the instruction in ID; x0 is never a real dependency
  assign load_use = ID_EXvalid & ID_EXmemRead & (ID_EXrd != REG_X0) & IF_IDvalid &
                    ((ID_EXrd == IF_IDrs1) | (ID_EXrd == IF_IDrs2));

  // A counted load-use bubble only happens when neither flush nor memory stall wins
  assign stall_event = load_use & ~EX_flush & ~memStall;

  assign PCWrite    = ~(memStall | (load_use & ~EX_flush));
  assign IF_IDWrite = PCWrite;

  // Priority mux: reset, flush bubble, memory-stall hold, load-use bubble, normal capture
  always_ff @(posedge clk) begin
    if (!rst_n || EX_flush || stall_event) begin
      ID_EXrs1    <= '0;
      ID_EXrs2    <= '0;
      ID_EXrd     <= '0;
      ID_EXctrl   <= '0;
      ID_EXrdata1 <= '0;
      ID_EXrdata2 <= '0;
      ID_EXimm    <= '0;
      ID_EXpc     <= '0;
      ID_EXvalid  <= 1'b0;
    end else if (!memStall) begin
      ID_EXrs1    <= IF_IDrs1;
      ID_EXrs2    <= IF_IDrs2;
      ID_EXrd     <= IF_IDrd;
      ID_EXctrl   <= IF_IDvalid ? ID_ctrl : '0;
      ID_EXrdata1 <= ID_rdata1;
      ID_EXrdata2 <= ID_rdata2;
      ID_EXimm    <= ID_imm;
      ID_EXpc     <= ID_pc;
      ID_EXvalid  <= IF_IDvalid;
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (stall_event),
    .count (stallCount)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (EX_flush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - directed self-checking bench for id_ex_hazard_reg
module tb_id_ex_hazard_reg;

  localparam logic [7:0] CTRL_LW  = 8'hD8;
  localparam logic [7:0] CTRL_ADD = 8'h82;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_IDrs1, IF_IDrs2, IF_IDrd;
  logic        IF_IDvalid;
  logic [7:0]  ID_ctrl;
  logic [31:0] ID_rdata1, ID_rdata2, ID_imm, ID_pc;
  logic        EX_flush, memStall;

  logic [4:0]  ID_EXrs1, ID_EXrs2, ID_EXrd;
  logic [7:0]  ID_EXctrl;
  logic        ID_EXregWrite, ID_EXmemRead, ID_EXvalid, PCWrite, IF_IDWrite;
  logic [31:0] ID_EXrdata1, ID_EXrdata2, ID_EXimm, ID_EXpc;
  logic [15:0] stallCount, flushCount;

  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [7:0]  s_ctrl;
  logic        s_regWrite, s_memRead, s_valid, s_PCWrite, s_IF_IDWrite;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc;
  logic [3:0]  s_stallCount, s_flushCount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg dut (
    .clk(clk), .rst_n(rst_n),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2), .IF_IDrd(IF_IDrd), .IF_IDvalid(IF_IDvalid),
    .ID_ctrl(ID_ctrl), .ID_rdata1(ID_rdata1), .ID_rdata2(ID_rdata2), .ID_imm(ID_imm), .ID_pc(ID_pc),
    .EX_flush(EX_flush), .memStall(memStall),
    .ID_EXrs1(ID_EXrs1), .ID_EXrs2(ID_EXrs2), .ID_EXrd(ID_EXrd), .ID_EXctrl(ID_EXctrl),
    .ID_EXregWrite(ID_EXregWrite), .ID_EXmemRead(ID_EXmemRead),
    .ID_EXrdata1(ID_EXrdata1), .ID_EXrdata2(ID_EXrdata2), .ID_EXimm(ID_EXimm), .ID_EXpc(ID_EXpc),
    .ID_EXvalid(ID_EXvalid), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  id_ex_hazard_reg #(.CNTW(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2), .IF_IDrd(IF_IDrd), .IF_IDvalid(IF_IDvalid),
    .ID_ctrl(ID_ctrl), .ID_rdata1(ID_rdata1), .ID_rdata2(ID_rdata2), .ID_imm(ID_imm), .ID_pc(ID_pc),
    .EX_flush(EX_flush), .memStall(memStall),
    .ID_EXrs1(s_rs1), .ID_EXrs2(s_rs2), .ID_EXrd(s_rd), .ID_EXctrl(s_ctrl),
    .ID_EXregWrite(s_regWrite), .ID_EXmemRead(s_memRead),
    .ID_EXrdata1(s_rdata1), .ID_EXrdata2(s_rdata2), .ID_EXimm(s_imm), .ID_EXpc(s_pc),
    .ID_EXvalid(s_valid), .PCWrite(s_PCWrite), .IF_IDWrite(s_IF_IDWrite),
    .stallCount(s_stallCount), .flushCount(s_flushCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [7:0] ctrl, input logic [31:0] pc);
    IF_IDvalid = v;
    IF_IDrs1   = rs1;
    IF_IDrs2   = rs2;
    IF_IDrd    = rd;
    ID_ctrl    = ctrl;
    ID_pc      = pc;
    ID_rdata1  = pc + 32'h1000;
    ID_rdata2  = pc + 32'h2000;
    ID_imm     = pc + 32'h3000;
  endtask

  task automatic do_reset();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 32'h0);
    EX_flush = 1'b0;
    memStall = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 8'($urandom), $urandom);
      EX_flush = 1'($urandom);
      memStall = 1'($urandom);
      tick();
    end
    checks++;
    if ({ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXctrl} !== 23'd0) begin
      failures++;
      $display("FAIL reset_fields got=%h exp=0", {ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXctrl});
    end
    checks++;
    if ({ID_EXrdata1, ID_EXrdata2, ID_EXimm, ID_EXpc} !== 128'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {ID_EXrdata1, ID_EXrdata2, ID_EXimm, ID_EXpc});
    end
    checks++;
    if ({ID_EXvalid, ID_EXregWrite, ID_EXmemRead} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=000", {ID_EXvalid, ID_EXregWrite, ID_EXmemRead});
    end
    checks++;
    if (stallCount !== 16'd0 || flushCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts got=%h/%h exp=0/0", stallCount, flushCount);
    end
    EX_flush = 1'b0;
    memStall = 1'b0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (PCWrite !== 1'b1 || IF_IDWrite !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_write got=%b%b exp=11", PCWrite, IF_IDWrite);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, CTRL_LW, 32'h40);
    tick();
    checks++;
    if (ID_EXmemRead !== 1'b1 || ID_EXrd !== 5'd5) begin
      failures++;
      $display("FAIL lu_lw_in_ex got=%b/%0d exp=1/5", ID_EXmemRead, ID_EXrd);
    end
    drive_id(1'b1, 5'd5, 5'd7, 5'd6, CTRL_ADD, 32'h44);
    #1;
    checks++;
    if (PCWrite !== 1'b0 || IF_IDWrite !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_write got=%b%b exp=00", PCWrite, IF_IDWrite);
    end
    tick();
    checks++;
    if (ID_EXctrl !== 8'h00 || ID_EXvalid !== 1'b0 || ID_EXrd !== 5'd0 || stallCount !== 16'd1) begin
      failures++;
      $display("FAIL lu_bubble got=ctrl %h valid %b rd %0d cnt %0d exp=ctrl 00 valid 0 rd 0 cnt 1",
               ID_EXctrl, ID_EXvalid, ID_EXrd, stallCount);
    end
    checks++;
    if (PCWrite !== 1'b1) begin
      failures++;
      $display("FAIL lu_release got=%b exp=1", PCWrite);
    end
    tick();
    checks++;
    if (ID_EXrs1 !== 5'd5 || ID_EXvalid !== 1'b1 || ID_EXctrl !== CTRL_ADD || ID_EXpc !== 32'h44 ||
        ID_EXrdata1 !== 32'h1044 || stallCount !== 16'd1) begin
      failures++;
      $display("FAIL lu_proceed got=rs1 %0d valid %b ctrl %h pc %h rd1 %h cnt %0d exp=5 1 82 44 1044 1",
               ID_EXrs1, ID_EXvalid, ID_EXctrl, ID_EXpc, ID_EXrdata1, stallCount);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive_id(1'b1, 5'd2, 5'd3, 5'd0, CTRL_LW, 32'h50);
    tick();
    drive_id(1'b1, 5'd0, 5'd4, 5'd6, CTRL_ADD, 32'h54);
    #1;
    checks++;
    if (PCWrite !== 1'b1) begin
      failures++;
      $display("FAIL x0_no_stall got=%b exp=1", PCWrite);
    end
    tick();
    checks++;
    if (ID_EXvalid !== 1'b1 || ID_EXctrl !== CTRL_ADD || ID_EXpc !== 32'h54 || stallCount !== 16'd0) begin
      failures++;
      $display("FAIL x0_load got=valid %b ctrl %h pc %h cnt %0d exp=1 82 54 0",
               ID_EXvalid, ID_EXctrl, ID_EXpc, stallCount);
    end
    drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_ADD, 32'h58);
    tick();
    drive_id(1'b1, 5'd9, 5'd5, 5'd8, CTRL_ADD, 32'h5C);
    #1;
    checks++;
    if (PCWrite !== 1'b1) begin
      failures++;
      $display("FAIL nonload_no_stall got=%b exp=1", PCWrite);
    end
    tick();
    checks++;
    if (ID_EXrs2 !== 5'd5 || ID_EXpc !== 32'h5C || ID_EXvalid !== 1'b1 || stallCount !== 16'd0) begin
      failures++;
      $display("FAIL nonload_load got=rs2 %0d pc %h valid %b cnt %0d exp=5 5c 1 0",
               ID_EXrs2, ID_EXpc, ID_EXvalid, stallCount);
    end
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 8'hFF, 32'h60);
    tick();
    checks++;
    if (ID_EXctrl !== 8'h00 || ID_EXvalid !== 1'b0) begin
      failures++;
      $display("FAIL invalid_ctrl_forced got=ctrl %h valid %b exp=00 0", ID_EXctrl, ID_EXvalid);
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, CTRL_LW, 32'h70);
    tick();
    drive_id(1'b1, 5'd5, 5'd7, 5'd6, CTRL_ADD, 32'h74);
    EX_flush = 1'b1;
    memStall = 1'b1;
    #1;
    checks++;
    if (PCWrite !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall_write got=%b exp=0", PCWrite);
    end
    tick();
    EX_flush = 1'b0;
    memStall = 1'b0;
    checks++;
    if (ID_EXctrl !== 8'h00 || ID_EXvalid !== 1'b0 || ID_EXrd !== 5'd0 || ID_EXpc !== 32'h0 ||
        flushCount !== 16'd1 || stallCount !== 16'd0) begin
      failures++;
      $display("FAIL flush_priority got=ctrl %h valid %b rd %0d pc %h fc %0d sc %0d exp=00 0 0 0 1 0",
               ID_EXctrl, ID_EXvalid, ID_EXrd, ID_EXpc, flushCount, stallCount);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, CTRL_ADD, 32'h100);
    tick();
    memStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 5'd4, 5'd5, 5'd6, CTRL_LW, 32'h104 + 32'(4 * i));
      #1;
      checks++;
      if (PCWrite !== 1'b0 || IF_IDWrite !== 1'b0) begin
        failures++;
        $display("FAIL stall_write_%0d got=%b%b exp=00", i, PCWrite, IF_IDWrite);
      end
      tick();
      checks++;
      if (ID_EXpc !== 32'h100 || ID_EXctrl !== CTRL_ADD || ID_EXrd !== 5'd3) begin
        failures++;
        $display("FAIL stall_hold_%0d got=pc %h ctrl %h rd %0d exp=100 82 3", i, ID_EXpc, ID_EXctrl, ID_EXrd);
      end
    end
    memStall = 1'b0;
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, CTRL_LW, 32'h200);
    tick();
    checks++;
    if (ID_EXpc !== 32'h200 || ID_EXmemRead !== 1'b1 || stallCount !== 16'd0 || flushCount !== 16'd0) begin
      failures++;
      $display("FAIL stall_release got=pc %h mr %b sc %0d fc %0d exp=200 1 0 0",
               ID_EXpc, ID_EXmemRead, stallCount, flushCount);
    end
    drive_id(1'b1, 5'd5, 5'd0, 5'd9, CTRL_ADD, 32'h204);
    memStall = 1'b1;
    tick();
    tick();
    checks++;
    if (ID_EXpc !== 32'h200 || ID_EXmemRead !== 1'b1 || stallCount !== 16'd0) begin
      failures++;
      $display("FAIL stall_over_loaduse got=pc %h mr %b sc %0d exp=200 1 0", ID_EXpc, ID_EXmemRead, stallCount);
    end
    memStall = 1'b0;
    tick();
    checks++;
    if (ID_EXvalid !== 1'b0 || ID_EXctrl !== 8'h00 || stallCount !== 16'd1) begin
      failures++;
      $display("FAIL loaduse_after_stall got=valid %b ctrl %h sc %0d exp=0 00 1", ID_EXvalid, ID_EXctrl, stallCount);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_id(1'b1, 5'd1, 5'd2, 5'd5, CTRL_LW, 32'h300);
      tick();
      drive_id(1'b1, 5'd5, 5'd3, 5'd6, CTRL_ADD, 32'h304);
      tick();
    end
    checks++;
    if (s_stallCount !== 4'hF || stallCount !== 16'd17) begin
      failures++;
      $display("FAIL sat_stall got=%h/%0d exp=f/17", s_stallCount, stallCount);
    end
    EX_flush = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    EX_flush = 1'b0;
    checks++;
    if (s_flushCount !== 4'hF || flushCount !== 16'd20 || s_stallCount !== 4'hF) begin
      failures++;
      $display("FAIL sat_flush got=%h/%0d/%h exp=f/20/f", s_flushCount, flushCount, s_stallCount);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (s_stallCount !== 4'h0 || s_flushCount !== 4'h0 || stallCount !== 16'd0) begin
      failures++;
      $display("FAIL sat_reset got=%h/%h/%0d exp=0/0/0", s_stallCount, s_flushCount, stallCount);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    EX_flush = 1'b0;
    memStall = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 32'h0);
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush_priority();
    test_mem_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
